keypad_matrix_scanner: RTL
==========================

KEYPAD_MATRIX_SCANNER -- requirements
Module: keypad_matrix_scanner

Interface
REQ-001 The module SHALL take parameter SCAN_DIV, default 4, giving clock cycles each column is driven (legal range 4..65535).
REQ-002 The module SHALL take parameter DEBOUNCE_SCANS, default 3, giving consecutive identical full scans required to accept a code (legal range 1..15).
REQ-003 clk  input  1  clock; reset rst, asynchronous, active-low; clock clk.
REQ-004 rst  input  1  asynchronous active-low reset.
REQ-005 en  input  1  scan enable; high = scanning.
REQ-006 row  input  4  keypad row sense lines, active-high (pulled low externally), asynchronous to clk.
REQ-007 col  output  3  column drive, one-hot active-high.
REQ-008 key_out  output  12  debounced one-hot key code, level.
REQ-009 key_valid  output  1  one-cycle pulse: key_out changed to a nonzero code.
REQ-010 key_release  output  1  one-cycle pulse: key_out changed from nonzero to zero.
REQ-011 key_multi  output  1  level: most recent full scan saw more than one key.

Function
REQ-012 Key map (row r, col c -> key_out bit) SHALL be: r0: c0 '1' bit0, c1 '2' bit1, c2 '3' bit2; r1: '4' bit3, '5' bit4, '6' bit5; r2: '7' bit6, '8' bit7, '9' bit8; r3: c0 '*' bit10, c1 '0' bit9, c2 '#' bit11.
REQ-013 row SHALL pass through a 2-flop synchronizer before any use.
REQ-014 A dwell counter SHALL count 0..SCAN_DIV-1 per column; col SHALL be 001, 010, 100 in order, advancing on the edge where the counter equals SCAN_DIV-1, wrapping 100 -> 001.
REQ-015 Synchronized row SHALL be sampled for the driven column on the edge where the dwell counter equals SCAN_DIV-1; full scan period is 3*SCAN_DIV cycles.
REQ-016 On the column-2 sampling edge (scan end), raw code SHALL be assembled from stored column-0/column-1 samples plus the current column-2 sample.
REQ-017 If raw has more than one bit set, raw SHALL be replaced by 12'h000 for debounce and key_multi SHALL be set to 1; otherwise key_multi SHALL be set to 0; key_multi updates only at scan end.
REQ-018 Debounce at scan end: if raw != cand then cand <= raw, n = 1; else n = min(cnt+1, DEBOUNCE_SCANS); cnt <= n.
REQ-019 At scan end, if n == DEBOUNCE_SCANS and raw != key_out, key_out SHALL take raw on that same edge.
REQ-020 key_valid SHALL be high for exactly the first cycle key_out shows a new nonzero value (including a direct change between two nonzero codes).
REQ-021 key_release SHALL be high for exactly the first cycle key_out shows 12'h000 after a nonzero value.
REQ-022 key_valid and key_release SHALL never be high in the same cycle and never high when key_out is unchanged.
REQ-023 Acceptance latency from a stable row pattern covering a full scan SHALL be at most (DEBOUNCE_SCANS+1)*3*SCAN_DIV+2 cycles.
REQ-024 When en is low: col SHALL be 000 from the next edge, dwell counter and column index SHALL reset to column 0, no scan end occurs, and cand, cnt, key_out, key_multi SHALL hold; pulses SHALL be 0.
REQ-025 When en rises, scanning SHALL restart at column 0, dwell count 0; partial column samples from before the pause SHALL be discarded.
REQ-026 cnt SHALL saturate at DEBOUNCE_SCANS; a held key SHALL produce no repeated key_valid.

Reset
REQ-027 rst low SHALL immediately force col=000, key_out=12'h000, key_valid=0, key_release=0, key_multi=0, cand=0, cnt=0, dwell counter=0, column index=0, synchronizer flops=0.
REQ-028 On the first clk edge after rst deasserts, col SHALL become 001 (if en high); reset mid-scan SHALL abandon the scan with no pulse.

Verification (SCAN_DIV=4, DEBOUNCE_SCANS=3)
REQ-029 Reset, en=1, row=0 -> col 001x4, 010x4, 100x4 repeating, key_out=0, no pulses for 10 scans.
REQ-030 Assert row=0010 only while col=010 ('5') for 5 scans, then row=0 -> key_out=12'h010 with one key_valid within 38 cycles, then 12'h000 with one key_release.
REQ-031 '#' (row3 during col=100) present on alternate scans for 4 scans, then steady -> key_out stays 0 until 3 consecutive steady scans, then 12'h800, single key_valid.
REQ-032 '1' and '9' held together -> key_multi=1 at first scan end, key_out stays 12'h000, no key_valid; release '9' -> key_out=12'h001 after 3 scans, key_multi=0.
REQ-033 key_out=12'h200 held, pulse rst low mid-column-1 -> all outputs 0 same cycle; after release col=001 next edge, key_out=12'h200 again after 3 scans with one key_valid.
REQ-034 '*' held, drop en for 20 cycles -> col=000 next edge, key_out=12'h400 held, no pulses; en high -> col=001 next edge, no new key_valid.

Source files
------------

// File: rtl/keypad_matrix_scanner.sv
// 3x4 keypad scanner: drives one column at a time, samples the synchronized rows,
// and debounces whole-scan codes into a one-hot key_out with change pulses.
//
// state  | meaning
// S_IDLE | scanning disabled (or just out of reset), col = 000
// S_COL0 | driving column 0
// S_COL1 | driving column 1
// S_COL2 | driving column 2, scan completes on its last dwell cycle
module keypad_matrix_scanner #(
  parameter int unsigned SCAN_DIV       = 4,
  parameter int unsigned DEBOUNCE_SCANS = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [3:0]  row,
  output logic [2:0]  col,
  output logic [11:0] key_out,
  output logic        key_valid,
  output logic        key_release,
  output logic        key_multi
);

  typedef enum logic [1:0] {S_IDLE, S_COL0, S_COL1, S_COL2} state_t;

  localparam logic [15:0] DWELL_LAST = 16'(SCAN_DIV - 1);
  localparam logic [3:0]  DB_MAX     = 4'(DEBOUNCE_SCANS);

  state_t      state, state_nxt;
  logic [15:0] dwell;
  logic [3:0]  row_s1, row_s2;
  logic [3:0]  samp0, samp1;
  logic [11:0] cand;
  logic [3:0]  cnt;

  logic        dwell_done, scan_end, multi, accept;
  logic [11:0] raw, raw_db;
  logic [3:0]  cnt_nxt;

  assign dwell_done = (state != S_IDLE) && (dwell == DWELL_LAST);
  assign scan_end   = en && (state == S_COL2) && dwell_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    col       = 3'b000;
    case (state)
      S_IDLE: state_nxt = S_COL0;
      S_COL0: begin
        col = 3'b001;
        if (dwell_done) state_nxt = S_COL1;
      end
      S_COL1: begin
        col = 3'b010;
        if (dwell_done) state_nxt = S_COL2;
      end
      S_COL2: begin
        col = 3'b100;
        if (dwell_done) state_nxt = S_COL0;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (!en) state_nxt = S_IDLE;
  end

  // Row 3 is the odd one out: '*' '0' '#' map to bits 10, 9, 11.
  always_comb begin
    raw     = {row_s2[3], samp0[3], samp1[3],
               row_s2[2], samp1[2], samp0[2],
               row_s2[1], samp1[1], samp0[1],
               row_s2[0], samp1[0], samp0[0]};
    multi   = (raw & (raw - 12'd1)) != 12'd0;
    raw_db  = multi ? 12'h000 : raw;
    if (raw_db != cand)     cnt_nxt = 4'd1;
    else if (cnt >= DB_MAX) cnt_nxt = DB_MAX;
    else                    cnt_nxt = cnt + 4'd1;
    accept  = (cnt_nxt == DB_MAX) && (raw_db != key_out);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_s1 <= '0;
      row_s2 <= '0;
    end else begin
      row_s1 <= row;
      row_s2 <= row_s1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dwell <= '0;
      samp0 <= '0;
      samp1 <= '0;
    end else begin
      if (!en || state == S_IDLE || dwell_done) dwell <= '0;
      else                                      dwell <= dwell + 16'd1;
      if (en && dwell_done && state == S_COL0) samp0 <= row_s2;
      if (en && dwell_done && state == S_COL1) samp1 <= row_s2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cand        <= '0;
      cnt         <= '0;
      key_out     <= '0;
      key_multi   <= 1'b0;
      key_valid   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      key_valid   <= 1'b0;
      key_release <= 1'b0;
      if (scan_end) begin
        key_multi <= multi;
        cand      <= raw_db;
        cnt       <= cnt_nxt;
        if (accept) begin
          key_out     <= raw_db;
          key_valid   <= (raw_db != 12'h000);
          key_release <= (raw_db == 12'h000);
        end
      end
    end
  end

endmodule
